fifo_ctrl: RTL and testbench
============================

// Module: fifo_ctrl
// PURPOSE
//  Pointer/flag controller that turns the 8x10 dual-address RAM into a FIFO.
//  Drives the RAM write/read enables and addresses from push/pop requests, keeps occupancy.
//  Produces full/empty, almost-full/almost-empty thresholds and sticky overflow/underflow.
//  Sits between the upstream producer and the downstream consumer of each PCIe lane buffer.
// PARAMETERS
//  ADDR_SIZE  3  RAM address width; RAM_DEPTH must equal 2**ADDR_SIZE
//  RAM_DEPTH  8  number of entries
//  AF_THRESH  6  almost_full asserted when count >= AF_THRESH
//  AE_THRESH  2  almost_empty asserted when count <= AE_THRESH
// PORTS
//  clk           in   1            clock, rising-edge
//  rst           in   1            synchronous reset, active-high
//  push          in   1            producer write request
//  pop           in   1            consumer read request
//  mem_wr_enb    out  1            RAM write enable (accepted push)
//  mem_wr_addr   out  ADDR_SIZE    RAM write address (= write pointer)
//  mem_rd_enb    out  1            RAM read enable (accepted pop)
//  mem_rd_addr   out  ADDR_SIZE    RAM read address (= read pointer)
//  full          out  1            count == RAM_DEPTH
//  empty         out  1            count == 0
//  almost_full   out  1            count >= AF_THRESH (used upstream as pause)
//  almost_empty  out  1            count <= AE_THRESH
//  fifo_count    out  ADDR_SIZE+1  current occupancy 0..RAM_DEPTH
//  fifo_state    out  2            0 EMPTY, 1 ACTIVE, 2 FULL, 3 ERROR
//  overflow      out  1            sticky: push refused
//  underflow     out  1            sticky: pop refused
// BEHAVIOUR
//  - Reset (rst=1 at clk edge): wr_ptr=rd_ptr=0, count=0, overflow=underflow=0,
//    fifo_state=EMPTY; outputs after reset: empty=1, almost_empty=1, others 0.
//  - pop_ok  = pop & ~empty.  push_ok = push & (~full | pop_ok).
//  - mem_wr_enb = push_ok, mem_rd_enb = pop_ok, both combinational, same cycle
//    as request; mem_wr_addr = wr_ptr, mem_rd_addr = rd_ptr always.
//  - Read data is valid from RAM in the same cycle pop_ok is high (zero latency).
//  - On clk: wr_ptr += push_ok, rd_ptr += pop_ok, wrap RAM_DEPTH-1 -> 0
//    (natural ADDR_SIZE-bit rollover).
//  - count += push_ok - pop_ok; both accepted -> count unchanged.
//  - full/empty/almost_* decoded from registered count: update 1 cycle after the edge.
//  - Simultaneous push+pop when empty: pop refused (underflow set), push accepted.
//  - Simultaneous push+pop when full: both accepted, count stays RAM_DEPTH.
//  - overflow set when push & ~push_ok; underflow set when pop & ~pop_ok;
//    both sticky until rst; FIFO keeps operating while flagged.
//  - FSM fifo_state (registered, next-state from next count/flags):
//    EMPTY -> ACTIVE on accepted push; ACTIVE -> FULL when next count==RAM_DEPTH;
//    ACTIVE -> EMPTY when next count==0; FULL -> ACTIVE on pop without push;
//    any -> ERROR when overflow or underflow becomes set; ERROR held until rst.
//  - rst mid-operation: pointers/count cleared same edge; RAM contents are not
//    the controller's concern; no enable asserted during the rst cycle.
// STRUCTURE
//  - Shared package/include: fifo_state encodings ST_EMPTY..ST_ERROR, default
//    ADDR_SIZE/RAM_DEPTH/thresholds, shared with the lane buffer top.
//  - No sub-module inside; fifo_ctrl + RAM are wired together one level up
//    in a wrapper named fifo_lane.
// TESTING
//  1 rst=1 two cycles -> empty=1, almost_empty=1, count=0, state=0, all enables 0.
//  2 8 pushes from empty -> count 8, full=1, almost_full from count 6, state=2,
//    wr addrs 0..7.
//  3 9th push while full, no pop -> mem_wr_enb=0, overflow=1, state=3, count 8.
//  4 fill to 8, push+pop same cycle -> both enables 1, rd_addr=0, wr_addr=0,
//    count stays 8.
//  5 pop from empty with push -> mem_rd_enb=0, underflow=1, mem_wr_enb=1, count 1.
//  6 12 push/pop pairs at count 3 -> pointers wrap 7->0, count stays 3, no error flags.

Source files
------------

// File: rtl/fifo_ctrl_pkg.sv
// Shared definitions for the lane buffer FIFO controller: state encodings,
// default geometry and thresholds, and the occupancy flag bundle.
package fifo_ctrl_pkg;

  localparam int DEF_ADDR_SIZE = 3;
  localparam int DEF_RAM_DEPTH = 8;
  localparam int DEF_AF_THRESH = 6;
  localparam int DEF_AE_THRESH = 2;

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_FULL   = 2'd2,
    ST_ERROR  = 2'd3
  } fifo_state_e;

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
  } fifo_flags_t;

endpackage : fifo_ctrl_pkg

// File: rtl/fifo_ctrl_if.sv
// Producer/consumer request and RAM-control bundle of one lane buffer.
// master = requester side (drives push/pop), slave = the controller.
interface fifo_ctrl_if
  import fifo_ctrl_pkg::*;
#(
  parameter int ADDR_SIZE = DEF_ADDR_SIZE
);

  logic                 push;
  logic                 pop;
  logic                 mem_wr_enb;
  logic [ADDR_SIZE-1:0] mem_wr_addr;
  logic                 mem_rd_enb;
  logic [ADDR_SIZE-1:0] mem_rd_addr;
  logic                 full;
  logic                 empty;
  logic                 almost_full;
  logic                 almost_empty;
  logic [ADDR_SIZE:0]   fifo_count;
  fifo_state_e          fifo_state;
  logic                 overflow;
  logic                 underflow;

  modport master (
    output push, pop,
    input  mem_wr_enb, mem_wr_addr, mem_rd_enb, mem_rd_addr,
    input  full, empty, almost_full, almost_empty,
    input  fifo_count, fifo_state, overflow, underflow
  );

  modport slave (
    input  push, pop,
    output mem_wr_enb, mem_wr_addr, mem_rd_enb, mem_rd_addr,
    output full, empty, almost_full, almost_empty,
    output fifo_count, fifo_state, overflow, underflow
  );

endinterface : fifo_ctrl_if

// File: rtl/fifo_ctrl.sv
// Pointer/flag controller that turns a 2**ADDR_SIZE-entry dual-address RAM
// into a FIFO: RAM enables/addresses, occupancy, thresholds and error flags.
module fifo_ctrl
  import fifo_ctrl_pkg::*;
#(
  parameter int ADDR_SIZE = DEF_ADDR_SIZE,
  parameter int RAM_DEPTH = DEF_RAM_DEPTH,
  parameter int AF_THRESH = DEF_AF_THRESH,
  parameter int AE_THRESH = DEF_AE_THRESH
) (
  input  logic        clk,
  input  logic        rst,
  fifo_ctrl_if.slave  bus
);

  localparam int CW = ADDR_SIZE + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(RAM_DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);
  localparam logic [CW-1:0] ZERO_C  = '0;

  logic [ADDR_SIZE-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_SIZE-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 overflow_q, overflow_d;
  logic                 underflow_q, underflow_d;
  fifo_state_e          state_q, state_d;

  fifo_flags_t          flags;
  logic                 push_ok;
  logic                 pop_ok;

  // Flags come from the registered count only, so they lag the edge by design.
  always_comb begin
    flags              = '0;
    flags.full         = (count_q == DEPTH_C);
    flags.empty        = (count_q == ZERO_C);
    flags.almost_full  = (count_q >= AF_C);
    flags.almost_empty = (count_q <= AE_C);
  end

  // A pop frees the slot a same-cycle push needs, so full does not block a paired push.
  assign pop_ok  = bus.pop  & ~flags.empty & ~rst;
  assign push_ok = bus.push & (~flags.full | pop_ok) & ~rst;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q  | (bus.push & ~push_ok);
    underflow_d = underflow_q | (bus.pop  & ~pop_ok);

    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    if (state_q == ST_ERROR || overflow_d || underflow_d) begin
      state_d = ST_ERROR;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (push_ok) begin
            state_d = (count_d == DEPTH_C) ? ST_FULL : ST_ACTIVE;
          end
        end
        ST_ACTIVE: begin
          if (count_d == DEPTH_C) begin
            state_d = ST_FULL;
          end else if (count_d == ZERO_C) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (pop_ok && !push_ok) begin
            state_d = ST_ACTIVE;
          end
        end
        default: state_d = ST_ERROR;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      state_q     <= ST_EMPTY;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      state_q     <= state_d;
    end
  end

  assign bus.mem_wr_enb   = push_ok;
  assign bus.mem_wr_addr  = wr_ptr_q;
  assign bus.mem_rd_enb   = pop_ok;
  assign bus.mem_rd_addr  = rd_ptr_q;
  assign bus.full         = flags.full;
  assign bus.empty        = flags.empty;
  assign bus.almost_full  = flags.almost_full;
  assign bus.almost_empty = flags.almost_empty;
  assign bus.fifo_count   = count_q;
  assign bus.fifo_state   = state_q;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;

endmodule : fifo_ctrl

// File: tb/tb_fifo_ctrl.sv
// Bench for fifo_ctrl: directed scenarios then random push/pop/reset traffic,
// every cycle compared against a queue-based occupancy model.
module tb_fifo_ctrl;
  import fifo_ctrl_pkg::*;

  localparam int DEPTH = 8;
  localparam int AF    = 6;
  localparam int AE    = 2;

  logic clk;
  logic rst;

  fifo_ctrl_if #(.ADDR_SIZE(3)) bus ();

  fifo_ctrl #(
    .ADDR_SIZE(3),
    .RAM_DEPTH(DEPTH),
    .AF_THRESH(AF),
    .AE_THRESH(AE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;
  int txn_idx = 0;

  // Reference model: queue holds the RAM slot of each stored entry, oldest first.
  int q[$];
  int n_push = 0;
  int n_pop  = 0;
  bit m_ovf  = 1'b0;
  bit m_unf  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, expected %0h (txn %0d)", tag, obs, exp, txn_idx);
    end
  endtask

  function automatic int exp_state(int sz, bit err);
    if (err)        return 3;
    if (sz == 0)    return 0;
    if (sz == DEPTH) return 2;
    return 1;
  endfunction

  task automatic step(input bit ps, input bit pp, input bit r);
    int sz;
    bit pop_ok;
    bit push_ok;
    bus.push = ps;
    bus.pop  = pp;
    rst      = r;
    sz       = q.size();
    pop_ok   = !r && pp && (sz > 0);
    push_ok  = !r && ps && ((sz < DEPTH) || pop_ok);

    @(negedge clk);
    chk("wr_enb",       32'(bus.mem_wr_enb),   32'(push_ok));
    chk("rd_enb",       32'(bus.mem_rd_enb),   32'(pop_ok));
    chk("wr_addr",      32'(bus.mem_wr_addr),  32'(n_push % DEPTH));
    chk("rd_addr",      32'(bus.mem_rd_addr),  32'(n_pop % DEPTH));
    if (pop_ok) begin
      chk("rd_order",   32'(bus.mem_rd_addr),  32'(q[0]));
    end
    chk("count",        32'(bus.fifo_count),   32'(sz));
    chk("full",         32'(bus.full),         32'(sz == DEPTH));
    chk("empty",        32'(bus.empty),        32'(sz == 0));
    chk("almost_full",  32'(bus.almost_full),  32'(sz >= AF));
    chk("almost_empty", 32'(bus.almost_empty), 32'(sz <= AE));
    chk("overflow",     32'(bus.overflow),     32'(m_ovf));
    chk("underflow",    32'(bus.underflow),    32'(m_unf));
    chk("state",        32'(bus.fifo_state),   32'(exp_state(sz, m_ovf || m_unf)));
    $display("txn %0d: rst=%0b push=%0b pop=%0b -> wr_enb=%0b@%0d rd_enb=%0b@%0d count=%0d state=%0d ovf=%0b unf=%0b",
             txn_idx, r, ps, pp, bus.mem_wr_enb, bus.mem_wr_addr, bus.mem_rd_enb,
             bus.mem_rd_addr, bus.fifo_count, bus.fifo_state, bus.overflow, bus.underflow);

    @(posedge clk);
    if (r) begin
      q.delete();
      n_push = 0;
      n_pop  = 0;
      m_ovf  = 1'b0;
      m_unf  = 1'b0;
    end else begin
      if (pop_ok) begin
        void'(q.pop_front());
        n_pop++;
      end
      if (push_ok) begin
        q.push_back(n_push % DEPTH);
        n_push++;
      end
      if (ps && !push_ok) m_ovf = 1'b1;
      if (pp && !pop_ok)  m_unf = 1'b1;
    end
    txn_idx++;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int pct_push[4];
    int pct_pop[4];
    pct_push = '{80, 50, 20, 60};
    pct_pop  = '{20, 50, 80, 60};

    rst      = 1'b1;
    bus.push = 1'b0;
    bus.pop  = 1'b0;
    @(posedge clk);
    #1;

    // Reset held two cycles, requests during reset must not enable the RAM
    step(0, 0, 1);
    step(1, 1, 1);

    // Fill from empty, then push into a full FIFO
    repeat (8) step(1, 0, 0);
    step(0, 0, 0);
    step(1, 0, 0);
    step(0, 0, 0);
    step(0, 0, 1);

    // Paired push+pop while full
    repeat (8) step(1, 0, 0);
    step(1, 1, 0);
    step(0, 0, 0);
    step(0, 0, 1);

    // Paired push+pop while empty
    step(1, 1, 0);
    step(0, 0, 0);
    step(0, 0, 1);

    // Steady state at count 3 across pointer wrap
    repeat (3) step(1, 0, 0);
    repeat (12) step(1, 1, 0);
    step(0, 0, 0);
    step(0, 0, 1);

    for (int ph = 0; ph < 4; ph++) begin
      for (int i = 0; i < 300; i++) begin
        step($urandom_range(99) < pct_push[ph],
             $urandom_range(99) < pct_pop[ph],
             $urandom_range(99) == 0);
      end
      step(0, 0, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule : tb_fifo_ctrl
